// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick_timer slice: FSM state encodings and state type.
// No ports; imported by tick_timer.
package tick_timer_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  typedef enum logic {
    ST_IDLE = IDLE,
    ST_RUN  = RUN
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous level and emits a registered one-cycle pulse
// on each rising edge, with edges suppressed while the chain primes after reset.
// Ports:
//   clk_in     - system clock
//   rst        - asynchronous active-low reset
//   async_in   - asynchronous input level (SYNC_STAGES must be at least 2)
//   edge_pulse - registered rising-edge pulse in the clk_in domain
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  localparam int unsigned PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned PW           = $clog2(PRIME_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [PW-1:0]          prime_cnt;
  logic                   primed_c;
  logic                   raw_edge_c;

  assign primed_c   = (prime_cnt == PW'(PRIME_CYCLES));
  assign raw_edge_c = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Synchroniser, edge register and prime counter. edge_q keeps tracking
  // during priming so a level already high at release never looks like an edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      prime_cnt  <= '0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      edge_q     <= sync_q[SYNC_STAGES-1];
      if (!primed_c) begin
        prime_cnt <= prime_cnt + PW'(1);
      end
      edge_pulse <= raw_edge_c & primed_c;
    end
  end

endmodule

// File: rtl/tick_timer.sv
// Converts divided slow_clk rising edges into clk_in ticks and counts them down
// from a programmable period, pulsing done on expiry (one-shot or auto-reload).
// Ports:
//   clk_in, rst        - system clock, asynchronous active-low reset
//   slow_clk           - divided clock, treated as asynchronous data
//   start, stop        - level-sampled run / abort commands (stop wins)
//   auto_reload        - reload period on expiry and keep running
//   period             - ticks per interval, sampled at each load
//   tick               - one-cycle pulse per slow_clk rising edge
//   busy               - high while running
//   done               - one-cycle pulse on expiry
//   remaining          - ticks left in the current interval
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         slow_clk,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  input  logic [W-1:0] period,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remaining
);

  state_t state;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_in    (clk_in),
    .rst       (rst),
    .async_in  (slow_clk),
    .edge_pulse(tick)
  );

  // Control FSM and down-counter; priority in RUN is stop > start > tick.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (period != '0) begin
              remaining <= period;
              state     <= ST_RUN;
              busy      <= 1'b1;
            end else begin
              // Zero-length interval expires immediately.
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            if (period != '0) begin
              remaining <= period;
            end else begin
              // Never sit in RUN with a zero count.
              remaining <= '0;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end
          end else if (tick) begin
            if (remaining > W'(1)) begin
              remaining <= remaining - W'(1);
            end else begin
              done <= 1'b1;
              if (auto_reload && (period != '0)) begin
                remaining <= period;
              end else begin
                remaining <= '0;
                state     <= ST_IDLE;
                busy      <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: stimulus pushes expected tick/done events,
// a monitor pops and compares whenever tick or done is high.
module tb_tick_timer;

  localparam int unsigned W = 16;

  typedef struct {
    int         cyc;
    logic       tick;
    logic       done;
    logic       busy;
    logic [W-1:0] rem;
  } exp_t;

  logic         clk_in = 1'b0;
  logic         rst = 1'b0;
  logic         slow_clk = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] period = '0;
  logic         tick;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tick_seen = 0;
  exp_t q[$];

  tick_timer #(.W(W), .SYNC_STAGES(2)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .slow_clk   (slow_clk),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .period     (period),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) if (tick) tick_seen <= tick_seen + 1;

  // Monitor: every tick/done event must match the next expected entry.
  always @(negedge clk_in) begin
    if (rst && (tick || done)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: cyc=%0d tick=%0b done=%0b busy=%0b rem=%0d, required no event",
                 cyc, tick, done, busy, remaining);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.tick != tick || e.done != done ||
            e.busy != busy || e.rem != remaining) begin
          failures++;
          $display("FAIL event: actual cyc=%0d tick=%0b done=%0b busy=%0b rem=%0d, required cyc=%0d tick=%0b done=%0b busy=%0b rem=%0d",
                   cyc, tick, done, busy, remaining, e.cyc, e.tick, e.done, e.busy, e.rem);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int c, input logic t, input logic d,
                              input logic b, input int r);
    exp_t e;
    e.cyc  = c;
    e.tick = t;
    e.done = d;
    e.busy = b;
    e.rem  = W'(r);
    return e;
  endfunction

  // One slow_clk period (4 high, 4 low): tick 3 cycles after the rise,
  // counter update (and any done) one cycle later.
  task automatic tick_ev(input int rem_b, input logic busy_b, input logic exp_done,
                         input int rem_a, input logic busy_a);
    int c0;
    @(posedge clk_in); #1;
    c0 = cyc;
    slow_clk = 1'b1;
    q.push_back(mk(c0 + 3, 1'b1, 1'b0, busy_b, rem_b));
    if (exp_done) q.push_back(mk(c0 + 4, 1'b0, 1'b1, busy_a, rem_a));
    repeat (4) @(posedge clk_in);
    #1 slow_clk = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("rem_after_tick", int'(remaining), rem_a);
    chk("busy_after_tick", int'(busy), int'(busy_a));
  endtask

  // Same slow_clk timing, but start/stop are asserted in the tick cycle.
  task automatic coincide(input logic stp, input int p, input int rem_exp, input logic busy_exp);
    int c0;
    @(posedge clk_in); #1;
    c0 = cyc;
    slow_clk = 1'b1;
    q.push_back(mk(c0 + 3, 1'b1, 1'b0, 1'b1, 2));
    repeat (3) @(posedge clk_in);
    #1;
    start  = 1'b1;
    stop   = stp;
    period = W'(p);
    @(posedge clk_in); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("coincide_busy", int'(busy), int'(busy_exp));
    chk("coincide_rem", int'(remaining), rem_exp);
    slow_clk = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("coincide_done_low", int'(done), 0);
  endtask

  task automatic do_start(input int p);
    @(posedge clk_in); #1;
    period = W'(p);
    start  = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_rem", int'(remaining), p);
  endtask

  initial begin
    // Reset state with slow_clk already high.
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rem", int'(remaining), 0);
    rst = 1'b1;
    repeat (20) @(posedge clk_in);
    #1;
    chk("no_spurious_tick", tick_seen, 0);
    slow_clk = 1'b0;
    repeat (4) @(posedge clk_in);
    tick_ev(0, 1'b0, 1'b0, 0, 1'b0);
    chk("first_tick_once", tick_seen, 1);

    // One-shot, period 4.
    auto_reload = 1'b0;
    do_start(4);
    tick_ev(4, 1'b1, 1'b0, 3, 1'b1);
    tick_ev(3, 1'b1, 1'b0, 2, 1'b1);
    tick_ev(2, 1'b1, 1'b0, 1, 1'b1);
    tick_ev(1, 1'b1, 1'b1, 0, 1'b0);

    // Zero period: done the cycle after start, never busy.
    begin
      int c0;
      @(posedge clk_in); #1;
      c0 = cyc;
      period = '0;
      start  = 1'b1;
      q.push_back(mk(c0 + 1, 1'b0, 1'b1, 1'b0, 0));
      @(posedge clk_in); #1;
      start = 1'b0;
      chk("zero_busy", int'(busy), 0);
      @(posedge clk_in); #1;
      chk("zero_done_single", int'(done), 0);
      chk("zero_busy_after", int'(busy), 0);
    end

    // Auto-reload, period 3, ten ticks: done on 3, 6, 9.
    auto_reload = 1'b1;
    do_start(3);
    for (int k = 1; k <= 10; k++) begin
      case (k % 3)
        1: tick_ev(3, 1'b1, 1'b0, 2, 1'b1);
        2: tick_ev(2, 1'b1, 1'b0, 1, 1'b1);
        default: tick_ev(1, 1'b1, 1'b1, 3, 1'b1);
      endcase
    end
    chk("auto_rem_final", int'(remaining), 2);
    @(posedge clk_in); #1 stop = 1'b1;
    @(posedge clk_in); #1 stop = 1'b0;
    chk("auto_stop_busy", int'(busy), 0);
    auto_reload = 1'b0;

    // Stop beats start and tick.
    do_start(5);
    tick_ev(5, 1'b1, 1'b0, 4, 1'b1);
    tick_ev(4, 1'b1, 1'b0, 3, 1'b1);
    tick_ev(3, 1'b1, 1'b0, 2, 1'b1);
    coincide(1'b1, 5, 2, 1'b0);

    // Restart with period 7; coincident tick not counted.
    do_start(5);
    tick_ev(5, 1'b1, 1'b0, 4, 1'b1);
    tick_ev(4, 1'b1, 1'b0, 3, 1'b1);
    tick_ev(3, 1'b1, 1'b0, 2, 1'b1);
    coincide(1'b0, 7, 7, 1'b1);
    tick_ev(7, 1'b1, 1'b0, 6, 1'b1);

    // Asynchronous reset mid-run, while tick is high.
    @(posedge clk_in); #1;
    slow_clk = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("pre_rst_tick", int'(tick), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_rem", int'(remaining), 0);
    slow_clk = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
